epp_host: RTL and testbench

Initiator side of the EPP parallel-port bus used by the tetris control path. It converts single-byte commands (address write/read, data write/read) from an on-chip requester into the four-phase EppAstb/EppDstb/EppWR/EppWait handshake, so a responder (the game's EPP command decoder) can be exercised and driven from inside the FPGA. It serves as a synthesizable stimulus source for board bring-up and as a bus model for the board-level bench.

---
 rtl/epp_pkg.sv | 40 ++++
 rtl/epp_if.sv | 26 ++
 rtl/epp_wait_sync.sv | 29 ++
 rtl/epp_host.sv | 216 +++++++++++++++++++++
 tb/tb_epp_host.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/epp_pkg.sv
// epp_pkg: definitions shared by the EPP host and the EPP command responder.
//   - epp_kind_e  : command encodings carried on cmd_kind.
//   - epp_state_e : host transfer FSM states.
//   - EPP_REG_*   : responder register addresses for the tetris control path.
//   - epp_is_addr : true when a command uses the address strobe.
//   - epp_is_read : true when a command reads the bus.
package epp_pkg;

    typedef enum logic [1:0] {
        EPP_ADDR_WR = 2'b00,
        EPP_DATA_WR = 2'b01,
        EPP_DATA_RD = 2'b10,
        EPP_ADDR_RD = 2'b11
    } epp_kind_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_SETUP   = 2'b01,
        ST_STROBE  = 2'b10,
        ST_RELEASE = 2'b11
    } epp_state_e;

    localparam logic [7:0] EPP_REG_MOVE_LEFT    = 8'h00;
    localparam logic [7:0] EPP_REG_MOVE_RIGHT   = 8'h01;
    localparam logic [7:0] EPP_REG_MOVE_DOWN    = 8'h02;
    localparam logic [7:0] EPP_REG_DROP         = 8'h03;
    localparam logic [7:0] EPP_REG_ROTATE_LEFT  = 8'h04;
    localparam logic [7:0] EPP_REG_ROTATE_RIGHT = 8'h05;

    // Address cycles are the two encodings whose bits agree (00, 11).
    function automatic logic epp_is_addr(input epp_kind_e kind);
        return (kind[0] == kind[1]);
    endfunction

    // The MSB of the encoding is also the EppWR level for the transfer.
    function automatic logic epp_is_read(input epp_kind_e kind);
        return kind[1];
    endfunction

endpackage

// File: rtl/epp_if.sv
// epp_if: command/response handshake between an on-chip requester and epp_host.
//   cmd_valid/cmd_ready/cmd_kind/cmd_data : one command, accepted on valid & ready.
//   rsp_valid/rsp_data/rsp_timeout        : one-cycle completion pulse and result.
// Modports: master = requester side, slave = epp_host side.
interface epp_if;
    import epp_pkg::*;

    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_kind;
    logic [7:0] cmd_data;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       rsp_timeout;

    modport master (
        output cmd_valid, cmd_kind, cmd_data,
        input  cmd_ready, rsp_valid, rsp_data, rsp_timeout
    );

    modport slave (
        input  cmd_valid, cmd_kind, cmd_data,
        output cmd_ready, rsp_valid, rsp_data, rsp_timeout
    );

endinterface

// File: rtl/epp_wait_sync.sv
// epp_wait_sync: two-flop synchronizer bringing the responder's asynchronous
// EppWait into the clk domain.
//   clk, rst_n : clock and synchronous active-low reset (both flops clear to 0).
//   async_in   : raw EppWait.
//   sync_out   : synchronized copy, two cycles behind async_in.
module epp_wait_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic sync_out
);

    logic meta_r;
    logic sync_r;

    // Two-stage resynchronizer; meta_r may go metastable, sync_r is the clean copy.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_r <= 1'b0;
            sync_r <= 1'b0;
        end else begin
            meta_r <= async_in;
            sync_r <= meta_r;
        end
    end

    assign sync_out = sync_r;

endmodule

// File: rtl/epp_host.sv
// epp_host: initiator side of the EPP parallel-port bus. Turns one command at a
// time (address/data, write/read) into the four-phase EppAstb/EppDstb/EppWR/EppWait
// handshake and reports completion or timeout on a one-cycle response pulse.
//   clk, rst_n : system clock, synchronous active-low reset.
//   cmd        : epp_if.slave command/response handshake.
//   EppAstb    : address strobe, active low.
//   EppDstb    : data strobe, active low.
//   EppWR      : 0 = write, 1 = read.
//   EppWait    : responder handshake, asynchronous, active high.
//   EppDB      : bidirectional data bus, driven only while writing.
// Every output, including the EppDB drive enable, comes straight from a flop.
module epp_host
    import epp_pkg::*;
#(
    parameter int SETUP_CYCLES   = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       rst_n,
    epp_if.slave       cmd,
    output logic       EppAstb,
    output logic       EppDstb,
    output logic       EppWR,
    input  logic       EppWait,
    inout  wire  [7:0] EppDB
);

    localparam int CNT_MAX = (TIMEOUT_CYCLES > SETUP_CYCLES) ? TIMEOUT_CYCLES : SETUP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] SETUP_LAST   = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic             wait_s;

    epp_state_e       state_r,     state_s;
    logic [CNT_W-1:0] cnt_r,       cnt_s;
    epp_kind_e        kind_r,      kind_s;
    logic [7:0]       data_r,      data_s;
    logic             stale_r,     stale_s;
    logic [7:0]       rd_byte_r,   rd_byte_s;
    logic             astb_r,      astb_s;
    logic             dstb_r,      dstb_s;
    logic             wr_r,        wr_s;
    logic             drv_r,       drv_s;
    logic             ready_r,     ready_s;
    logic             rsp_valid_r, rsp_valid_s;
    logic             rsp_to_r,    rsp_to_s;
    logic [7:0]       rsp_data_r,  rsp_data_s;

    epp_wait_sync u_wait_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (EppWait),
        .sync_out (wait_s)
    );

    // State register plus every registered output and datapath flop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            cnt_r       <= '0;
            kind_r      <= EPP_ADDR_WR;
            data_r      <= 8'h00;
            stale_r     <= 1'b0;
            rd_byte_r   <= 8'h00;
            astb_r      <= 1'b1;
            dstb_r      <= 1'b1;
            wr_r        <= 1'b1;
            drv_r       <= 1'b0;
            ready_r     <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_to_r    <= 1'b0;
            rsp_data_r  <= 8'h00;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            kind_r      <= kind_s;
            data_r      <= data_s;
            stale_r     <= stale_s;
            rd_byte_r   <= rd_byte_s;
            astb_r      <= astb_s;
            dstb_r      <= dstb_s;
            wr_r        <= wr_s;
            drv_r       <= drv_s;
            ready_r     <= ready_s;
            rsp_valid_r <= rsp_valid_s;
            rsp_to_r    <= rsp_to_s;
            rsp_data_r  <= rsp_data_s;
        end
    end

    // Next-state and next-output logic for the transfer FSM.
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        kind_s      = kind_r;
        data_s      = data_r;
        stale_s     = stale_r;
        rd_byte_s   = rd_byte_r;
        astb_s      = astb_r;
        dstb_s      = dstb_r;
        wr_s        = wr_r;
        drv_s       = drv_r;
        ready_s     = 1'b0;
        rsp_valid_s = 1'b0;
        rsp_to_s    = 1'b0;
        rsp_data_s  = rsp_data_r;

        case (state_r)
            ST_IDLE: begin
                // ready_r lags the return to IDLE by one cycle, so it never
                // overlaps the rsp_valid pulse.
                if (cmd.cmd_valid && ready_r) begin
                    state_s = ST_SETUP;
                    cnt_s   = '0;
                    kind_s  = epp_kind_e'(cmd.cmd_kind);
                    data_s  = cmd.cmd_data;
                    wr_s    = epp_is_read(epp_kind_e'(cmd.cmd_kind));
                    drv_s   = ~epp_is_read(epp_kind_e'(cmd.cmd_kind));
                end else begin
                    ready_s = 1'b1;
                end
            end

            ST_SETUP: begin
                if (cnt_r == SETUP_LAST) begin
                    state_s = ST_STROBE;
                    cnt_s   = '0;
                    // A handshake already high here belongs to nobody; it must
                    // be seen low before a rising edge counts.
                    stale_s = wait_s;
                    if (epp_is_addr(kind_r)) begin
                        astb_s = 1'b0;
                    end else begin
                        dstb_s = 1'b0;
                    end
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end

            ST_STROBE: begin
                if (wait_s && !stale_r) begin
                    state_s   = ST_RELEASE;
                    cnt_s     = '0;
                    astb_s    = 1'b1;
                    dstb_s    = 1'b1;
                    if (epp_is_read(kind_r)) begin
                        rd_byte_s = EppDB;
                    end else begin
                        rd_byte_s = 8'h00;
                    end
                end else if (cnt_r == TIMEOUT_LAST) begin
                    state_s     = ST_IDLE;
                    cnt_s       = '0;
                    astb_s      = 1'b1;
                    dstb_s      = 1'b1;
                    wr_s        = 1'b1;
                    drv_s       = 1'b0;
                    rsp_valid_s = 1'b1;
                    rsp_to_s    = 1'b1;
                    rsp_data_s  = 8'h00;
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                    if (!wait_s) begin
                        stale_s = 1'b0;
                    end else begin
                        stale_s = stale_r;
                    end
                end
            end

            ST_RELEASE: begin
                if (!wait_s) begin
                    state_s     = ST_IDLE;
                    cnt_s       = '0;
                    wr_s        = 1'b1;
                    drv_s       = 1'b0;
                    rsp_valid_s = 1'b1;
                    rsp_data_s  = rd_byte_r;
                end else if (cnt_r == TIMEOUT_LAST) begin
                    state_s     = ST_IDLE;
                    cnt_s       = '0;
                    astb_s      = 1'b1;
                    dstb_s      = 1'b1;
                    wr_s        = 1'b1;
                    drv_s       = 1'b0;
                    rsp_valid_s = 1'b1;
                    rsp_to_s    = 1'b1;
                    rsp_data_s  = 8'h00;
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end

            default: begin
                state_s = ST_IDLE;
                cnt_s   = '0;
                astb_s  = 1'b1;
                dstb_s  = 1'b1;
                wr_s    = 1'b1;
                drv_s   = 1'b0;
            end
        endcase
    end

    assign EppAstb         = astb_r;
    assign EppDstb         = dstb_r;
    assign EppWR           = wr_r;
    assign EppDB           = drv_r ? data_r : 8'hzz;
    assign cmd.cmd_ready   = ready_r;
    assign cmd.rsp_valid   = rsp_valid_r;
    assign cmd.rsp_data    = rsp_data_r;
    assign cmd.rsp_timeout = rsp_to_r;

endmodule

// File: tb/tb_epp_host.sv
// tb_epp_host: directed bench for epp_host with SETUP_CYCLES=2, TIMEOUT_CYCLES=16
// and a behavioural responder (normal / never-waits / stuck-high modes).
module tb_epp_host;
    import epp_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       EppAstb;
    logic       EppDstb;
    logic       EppWR;
    logic       resp_wait;
    wire  [7:0] EppDB;

    epp_if bus ();

    epp_host #(
        .SETUP_CYCLES   (2),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .cmd     (bus),
        .EppAstb (EppAstb),
        .EppDstb (EppDstb),
        .EppWR   (EppWR),
        .EppWait (resp_wait),
        .EppDB   (EppDB)
    );

    int n_chk = 0;
    int n_bad = 0;

    // Responder: mode 0 raises EppWait 4 cycles after a strobe falls and drops it
    // 2 cycles after the strobe rises; mode 1 never raises it; mode 2 holds it high.
    logic [1:0] resp_mode = 2'd0;
    logic [7:0] resp_byte = 8'hA5;
    logic [7:0] resp_addr = 8'h00;
    int         move_down_n = 0;
    int         lo_cnt = 0;
    int         hi_cnt = 0;
    wire        strb_lo  = !EppAstb || !EppDstb;
    wire        resp_drv = resp_wait && EppWR && strb_lo && (resp_mode == 2'd0);

    assign EppDB = resp_drv ? resp_byte : 8'hzz;

    always #5 clk = ~clk;

    // Behavioural responder and its register-write observer.
    always @(posedge clk) begin
        if (resp_mode == 2'd1) begin
            resp_wait <= 1'b0;
            lo_cnt    <= 0;
            hi_cnt    <= 0;
        end else if (resp_mode == 2'd2) begin
            resp_wait <= 1'b1;
            lo_cnt    <= 0;
            hi_cnt    <= 0;
        end else if (strb_lo) begin
            hi_cnt <= 0;
            lo_cnt <= lo_cnt + 1;
            if (lo_cnt == 3 && !resp_wait) begin
                resp_wait <= 1'b1;
                if (!EppWR && !EppAstb) resp_addr <= EppDB;
                if (!EppWR && !EppDstb && resp_addr == EPP_REG_MOVE_DOWN && EppDB == 8'h01)
                    move_down_n <= move_down_n + 1;
            end
        end else begin
            lo_cnt <= 0;
            if (resp_wait) begin
                hi_cnt <= hi_cnt + 1;
                if (hi_cnt == 1) resp_wait <= 1'b0;
            end else begin
                hi_cnt <= 0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Issue one command from a negedge and watch it until rsp_valid (k = cycles
    // after the accept edge), collecting what the bus did along the way.
    task automatic issue(input logic [1:0] kind, input logic [7:0] data,
                         output int k_rsp, output int n_astb, output int n_dstb,
                         output int n_wr_hi, output logic wr1, output logic [7:0] db1,
                         output logic strb2, output logic astb3, output logic dstb3,
                         output logic [7:0] r_data, output logic r_to, output logic rdy_next);
        int guard;
        guard = 0; k_rsp = -1; n_astb = 0; n_dstb = 0; n_wr_hi = 0;
        wr1 = 1'b0; db1 = 8'h00; strb2 = 1'b0; astb3 = 1'b1; dstb3 = 1'b1;
        r_data = 8'h00; r_to = 1'b0;
        while (!bus.cmd_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("ready_before_cmd", {31'd0, bus.cmd_ready}, 32'd1);
        bus.cmd_kind  = kind;
        bus.cmd_data  = data;
        bus.cmd_valid = 1'b1;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            if (k == 1) begin wr1 = EppWR; db1 = EppDB; end
            if (k == 2) strb2 = EppAstb & EppDstb;
            if (k == 3) begin astb3 = EppAstb; dstb3 = EppDstb; end
            if (!EppAstb) n_astb++;
            if (!EppDstb) n_dstb++;
            if (EppWR) n_wr_hi++;
            if (bus.rsp_valid) begin
                k_rsp  = k;
                r_data = bus.rsp_data;
                r_to   = bus.rsp_timeout;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        rdy_next = bus.cmd_ready;
    endtask

    int         k_rsp, n_astb, n_dstb, n_wr_hi;
    logic       wr1, strb2, astb3, dstb3, r_to, rdy_next;
    logic [7:0] db1, r_data;

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int md0, n_acc, acc1, acc2, rsp1, rsp_n, guard;
        logic next_payload, drop_valid;
        clk = 1'b0;
        rst_n = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_kind  = 2'b00;
        bus.cmd_data  = 8'h00;
        repeat (3) @(negedge clk);

        // Reset values
        check("rst_astb",    {31'd0, EppAstb}, 32'd1);
        check("rst_dstb",    {31'd0, EppDstb}, 32'd1);
        check("rst_wr",      {31'd0, EppWR}, 32'd1);
        check("rst_ready",   {31'd0, bus.cmd_ready}, 32'd0);
        check("rst_rsp_vld", {31'd0, bus.rsp_valid}, 32'd0);
        check("rst_rsp_to",  {31'd0, bus.rsp_timeout}, 32'd0);
        check("rst_rsp_dat", {24'd0, bus.rsp_data}, 32'h00);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_rise", {31'd0, bus.cmd_ready}, 32'd1);

        // Address write 0x03, normal responder
        resp_mode = 2'd0;
        issue(2'b00, 8'h03, k_rsp, n_astb, n_dstb, n_wr_hi, wr1, db1, strb2, astb3, dstb3, r_data, r_to, rdy_next);
        check("aw_wr_t1",    {31'd0, wr1}, 32'd0);
        check("aw_db_t1",    {24'd0, db1}, 32'h03);
        check("aw_strb_t2",  {31'd0, strb2}, 32'd1);
        check("aw_astb_t3",  {31'd0, astb3}, 32'd0);
        check("aw_astb_len", n_astb, 32'd7);
        check("aw_dstb_len", n_dstb, 32'd0);
        check("aw_wr_hi",    n_wr_hi, 32'd1);
        check("aw_rsp_k",    k_rsp, 32'd15);
        check("aw_rsp_to",   {31'd0, r_to}, 32'd0);
        check("aw_rsp_dat",  {24'd0, r_data}, 32'h00);
        check("aw_ready",    {31'd0, rdy_next}, 32'd1);

        // Data read, responder drives 0xA5
        resp_byte = 8'hA5;
        issue(2'b10, 8'h77, k_rsp, n_astb, n_dstb, n_wr_hi, wr1, db1, strb2, astb3, dstb3, r_data, r_to, rdy_next);
        check("dr_dstb_t3",  {31'd0, dstb3}, 32'd0);
        check("dr_astb_len", n_astb, 32'd0);
        check("dr_dstb_len", n_dstb, 32'd7);
        check("dr_wr_hi",    n_wr_hi, 32'd15);
        check("dr_rsp_k",    k_rsp, 32'd15);
        check("dr_rsp_to",   {31'd0, r_to}, 32'd0);
        check("dr_rsp_dat",  {24'd0, r_data}, 32'hA5);

        // Responder never answers: address read times out after 16 strobe cycles
        resp_mode = 2'd1;
        issue(2'b11, 8'h00, k_rsp, n_astb, n_dstb, n_wr_hi, wr1, db1, strb2, astb3, dstb3, r_data, r_to, rdy_next);
        check("to_astb_len", n_astb, 32'd16);
        check("to_rsp_k",    k_rsp, 32'd19);
        check("to_rsp_to",   {31'd0, r_to}, 32'd1);
        check("to_rsp_dat",  {24'd0, r_data}, 32'h00);
        check("to_ready",    {31'd0, rdy_next}, 32'd1);

        // EppWait stuck high before the command: no completion, only timeout
        resp_mode = 2'd2;
        repeat (4) @(negedge clk);
        issue(2'b01, 8'h5A, k_rsp, n_astb, n_dstb, n_wr_hi, wr1, db1, strb2, astb3, dstb3, r_data, r_to, rdy_next);
        check("st_dstb_len", n_dstb, 32'd16);
        check("st_rsp_k",    k_rsp, 32'd19);
        check("st_rsp_to",   {31'd0, r_to}, 32'd1);
        resp_mode = 2'd0;
        repeat (6) @(negedge clk);

        // Reset while EppDstb is low during a data write
        resp_mode = 2'd1;
        guard = 0;
        while (!bus.cmd_ready && guard < 50) begin @(negedge clk); guard++; end
        bus.cmd_kind  = 2'b01;
        bus.cmd_data  = 8'h3C;
        bus.cmd_valid = 1'b1;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("mr_dstb_low", {31'd0, EppDstb}, 32'd0);
        check("mr_db_drv",   {31'd0, (EppDB === 8'h3C)}, 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check("mr_dstb",     {31'd0, EppDstb}, 32'd1);
        check("mr_astb",     {31'd0, EppAstb}, 32'd1);
        check("mr_wr",       {31'd0, EppWR}, 32'd1);
        check("mr_db_rel",   {31'd0, (EppDB === 8'h3C)}, 32'd0);
        check("mr_ready",    {31'd0, bus.cmd_ready}, 32'd0);
        check("mr_rsp_vld",  {31'd0, bus.rsp_valid}, 32'd0);
        rst_n = 1'b1;
        resp_mode = 2'd0;
        @(negedge clk);
        check("mr_ready_rise", {31'd0, bus.cmd_ready}, 32'd1);

        // Back-to-back: address write move_down, then data write 0x01, valid held
        md0 = move_down_n;
        n_acc = 0; acc1 = -1; acc2 = -1; rsp1 = -1; rsp_n = 0;
        next_payload = 1'b0; drop_valid = 1'b0;
        bus.cmd_kind  = 2'b00;
        bus.cmd_data  = EPP_REG_MOVE_DOWN;
        bus.cmd_valid = 1'b1;
        for (int c = 0; c < 80; c++) begin
            if (next_payload) begin
                bus.cmd_kind = 2'b01;
                bus.cmd_data = 8'h01;
                next_payload = 1'b0;
            end
            if (drop_valid) begin
                bus.cmd_valid = 1'b0;
                drop_valid = 1'b0;
            end
            if (bus.rsp_valid) begin
                rsp_n++;
                if (rsp1 < 0) rsp1 = c;
            end
            if (rsp_n == 2) break;
            if (bus.cmd_valid && bus.cmd_ready) begin
                n_acc++;
                if (n_acc == 1) begin acc1 = c; next_payload = 1'b1; end
                else begin acc2 = c; drop_valid = 1'b1; end
            end
            @(negedge clk);
        end
        bus.cmd_valid = 1'b0;
        check("bb_accepts",    n_acc, 32'd2);
        check("bb_rsp_count",  rsp_n, 32'd2);
        check("bb_rsp1_delay", rsp1 - acc1, 32'd15);
        check("bb_acc_period", acc2 - acc1, 32'd16);
        check("bb_move_down",  move_down_n - md0, 32'd1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
